irq_ctrl_n: RTL and testbench
=============================

Name: irq_ctrl_n

Overview:
Parametrised external-interrupt controller that aggregates NUM_SRC asynchronous interrupt inputs into the single machine external interrupt to the core.
Each source has enable, edge/level mode, polarity and a pending status bit.
It sits on the dma_io register bus and adds a claim register that reports the lowest-numbered pending source.
The read-data path is daisy-chained like every other I/O block on the bus.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..32)
SYNC_STAGES, 2, synchroniser flops per source input (>=2)
BASE_ADR, 14'h3E80, word address of register 0 (low 3 bits must be 0)

Ports:
clk  in  1  clock
rst_n  in  1  reset
int_src  in  NUM_SRC  raw asynchronous interrupt inputs
csr_meie  in  1  mie.MEIE; gates setting of status
csr_rmie  in  1  mstatus.MIE; gates g_interrupt
g_interrupt  out  1  level interrupt request to core
g_interrupt_1shot  out  1  one-cycle pulse on g_interrupt rising edge
dma_io_we  in  1  bus write strobe
dma_io_wadr  in  14  write word address [15:2]
dma_io_wdata  in  32  write data
dma_io_radr  in  14  read word address [15:2]
dma_io_radr_en  in  1  read strobe
dma_io_rdata_in  in  32  upstream read data (chain input)
dma_io_rdata  out  32  read data (chain output)

Behaviour:
- Reset is asynchronous, active-low rst_n; clock is clk. All flops are cleared by reset.
- Outputs after reset: g_interrupt=0, g_interrupt_1shot=0, dma_io_rdata=dma_io_rdata_in.
- Register map (word offset from BASE_ADR). Bits above NUM_SRC-1 read 0 and ignore writes.
  - +0 ENABLE: RW, reset 0.
  - +1 STATUS: edge-mode bits are W1C (write 1 clears, write 0 no effect); level-mode bits are RO.
  - +2 MODE: RW, 0=edge, 1=level, reset 0.
  - +3 POLARITY: RW, 0=active-high/rising, 1=active-low/falling, reset 0.
  - +4 CLAIM: RO, {valid[31], 23'd0, id[7:0]}.
  - +5..+7: read 0.
- Per-source datapath:
  - sync = SYNC_STAGES-flop chain of int_src[i]; adj = sync ^ POLARITY[i]; prev <= adj.
- Edge mode:
  - An edge is adj & ~prev.
  - STATUS[i] sets on the next clock when edge & ENABLE[i] & csr_meie.
  - Latency: with SYNC_STAGES=2, STATUS rises on the 3rd clk edge after the input asserts (SYNC_STAGES+1 in general).
- Simultaneous set and W1C on the same bit: set wins, so a new edge is never lost.
- Level mode: STATUS[i] <= adj & ENABLE[i] & csr_meie every cycle. W1C writes are ignored.
- Mode change:
  - edge->level: STATUS follows the level rule from the next cycle.
  - level->edge: STATUS keeps its current value, then follows edge rules.
- POLARITY write: prev[i] is loaded with sync ^ new POLARITY[i] on the write edge, so no spurious edge is generated.
- Clearing ENABLE[i] does not clear STATUS[i] but removes it from pending.
- pending = STATUS & ENABLE.
- g_interrupt = |pending & csr_rmie, combinational from flops.
- g_interrupt_1shot = g_interrupt & ~g_interrupt_dly, where g_interrupt_dly is registered.
- CLAIM: valid = |pending; id = lowest index with pending set, 0 when none. Reading CLAIM has no side effect.
- Reads:
  - Address decode is registered on dma_io_radr_en; data appears on dma_io_rdata exactly 1 cycle later.
  - The value is sampled from the registers in that later cycle.
  - Otherwise dma_io_rdata = dma_io_rdata_in.
- Back-to-back reads every cycle are supported.
- A write and a read to the same register in the same cycle: the read returns the post-write value.

Decomposition:
- Package irq_ctrl_pkg: register offset constants (OFS_ENABLE=0, OFS_STATUS=1, OFS_MODE=2, OFS_POL=3, OFS_CLAIM=4) and CLAIM_VALID_BIT=31.
- Sub-module irq_src_cell: one per source via generate. Contains the synchroniser, prev, edge/level logic and the STATUS flop; its inputs are enable, mode, pol, meie, clr and pol_we.
- Top level holds the bus decode, priority encoder and read mux.

Test Plan:
- Reset, then read all of +0..+7 -> all 0. Read latency is 1 cycle. An unrelated address passes dma_io_rdata_in=32'hA5A5_0000 through.
- ENABLE=8'h05, meie=rmie=1, rising edge on int_src[2] -> STATUS=8'h04 after 3 clks. g_interrupt=1, one 1-cycle 1shot pulse. CLAIM=32'h8000_0002.
- Write STATUS=8'h04 in the same cycle as a new edge on src2 -> STATUS stays 8'h04 (set wins). A later W1C with no edge -> 0 and g_interrupt=0.
- MODE[0]=1, POL[0]=1, ENABLE[0]=1, int_src[0] held low -> STATUS[0]=1. Writing STATUS=1 has no effect. Driving src0 high -> STATUS[0]=0 after 3 clks.
- src3 and src6 pending together -> CLAIM id=3. After W1C of bit3 -> id=6. csr_rmie=0 -> g_interrupt=0 while STATUS is still nonzero.
- With src1 high and edge mode, flip POLARITY[1] -> no STATUS set. csr_meie=0 during an edge -> no STATUS set. rst_n asserted mid-pending -> all outputs 0 immediately.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the external-interrupt controller: register offsets
// within the 8-word block and the CLAIM word layout.
package irq_ctrl_pkg;

  localparam logic [2:0] OFS_ENABLE = 3'd0;
  localparam logic [2:0] OFS_STATUS = 3'd1;
  localparam logic [2:0] OFS_MODE   = 3'd2;
  localparam logic [2:0] OFS_POL    = 3'd3;
  localparam logic [2:0] OFS_CLAIM  = 3'd4;

  localparam int CLAIM_VALID_BIT = 31;

  function automatic logic [31:0] claim_word(input logic valid, input logic [7:0] id);
    logic [31:0] w;
    w                  = '0;
    w[CLAIM_VALID_BIT] = valid;
    w[7:0]             = id;
    return w;
  endfunction

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: input synchroniser, polarity adjust, edge detect and
// the STATUS flop with edge (sticky, W1C) or level (follows input) behaviour.
module irq_src_cell
  import irq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic int_src,
  input  logic enable,
  input  logic mode,
  input  logic pol,
  input  logic pol_wval,
  input  logic meie,
  input  logic clr,
  input  logic pol_we,
  output logic status
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync;
  logic                   adj;
  logic                   edge_det;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign adj      = sync ^ pol;
  assign edge_det = adj & ~prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      status <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], int_src};
      // Reloading prev with the new polarity hides the polarity flip itself.
      prev_q <= pol_we ? (sync ^ pol_wval) : adj;
      if (mode) begin
        status <= adj & enable & meie;
      end else if (edge_det & enable & meie) begin
        status <= 1'b1;
      end else if (clr) begin
        status <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_n.sv
// External-interrupt controller on the dma_io bus: ENABLE/STATUS/MODE/POLARITY
// registers, lowest-index CLAIM, and a daisy-chained registered read path.
module irq_ctrl_n
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_SRC     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [13:0] BASE_ADR    = 14'h3E80
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] int_src,
  input  logic               csr_meie,
  input  logic               csr_rmie,
  output logic               g_interrupt,
  output logic               g_interrupt_1shot,
  input  logic               dma_io_we,
  input  logic [13:0]        dma_io_wadr,
  input  logic [31:0]        dma_io_wdata,
  input  logic [13:0]        dma_io_radr,
  input  logic               dma_io_radr_en,
  input  logic [31:0]        dma_io_rdata_in,
  output logic [31:0]        dma_io_rdata
);

  localparam logic [10:0] BLK_ADR = BASE_ADR[13:3];

  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] mode_q;
  logic [NUM_SRC-1:0] pol_q;
  logic [NUM_SRC-1:0] status;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] wdata_src;
  logic [NUM_SRC-1:0] clr_vec;

  logic       wr_hit;
  logic [2:0] wr_ofs;
  logic       wr_status;
  logic       wr_pol;
  logic       unused_wdata;

  logic       claim_valid;
  logic [7:0] claim_id;
  logic       g_dly_q;

  logic       rd_hit_q;
  logic [2:0] rd_ofs_q;
  logic [31:0] rd_val;

  // Bus write decode
  assign wr_hit       = dma_io_we && (dma_io_wadr[13:3] == BLK_ADR);
  assign wr_ofs       = dma_io_wadr[2:0];
  assign wr_status    = wr_hit && (wr_ofs == OFS_STATUS);
  assign wr_pol       = wr_hit && (wr_ofs == OFS_POL);
  assign wdata_src    = dma_io_wdata[NUM_SRC-1:0];
  assign clr_vec      = wr_status ? wdata_src : '0;
  assign unused_wdata = ^dma_io_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= '0;
      mode_q   <= '0;
      pol_q    <= '0;
    end else if (wr_hit) begin
      case (wr_ofs)
        OFS_ENABLE: enable_q <= wdata_src;
        OFS_MODE:   mode_q   <= wdata_src;
        OFS_POL:    pol_q    <= wdata_src;
        default:    ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_src_cell #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .int_src (int_src[i]),
      .enable  (enable_q[i]),
      .mode    (mode_q[i]),
      .pol     (pol_q[i]),
      .pol_wval(wdata_src[i]),
      .meie    (csr_meie),
      .clr     (clr_vec[i]),
      .pol_we  (wr_pol),
      .status  (status[i])
    );
  end

  assign pending     = status & enable_q;
  assign claim_valid = |pending;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    claim_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) claim_id = 8'(i);
    end
  end

  assign g_interrupt       = claim_valid & csr_rmie;
  assign g_interrupt_1shot = g_interrupt & ~g_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_dly_q  <= 1'b0;
      rd_hit_q <= 1'b0;
      rd_ofs_q <= '0;
    end else begin
      g_dly_q  <= g_interrupt;
      rd_hit_q <= dma_io_radr_en && (dma_io_radr[13:3] == BLK_ADR);
      rd_ofs_q <= dma_io_radr[2:0];
    end
  end

  // Registers are sampled in the cycle after the strobe, so a same-cycle write is visible.
  always_comb begin
    rd_val = '0;
    case (rd_ofs_q)
      OFS_ENABLE: rd_val[NUM_SRC-1:0] = enable_q;
      OFS_STATUS: rd_val[NUM_SRC-1:0] = status;
      OFS_MODE:   rd_val[NUM_SRC-1:0] = mode_q;
      OFS_POL:    rd_val[NUM_SRC-1:0] = pol_q;
      OFS_CLAIM:  rd_val              = claim_word(claim_valid, claim_id);
      default:    rd_val              = '0;
    endcase
  end

  assign dma_io_rdata = rd_hit_q ? rd_val : dma_io_rdata_in;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Self-checking bench for irq_ctrl_n: directed scenarios followed by random
// traffic, all checked every cycle against a behavioural register model.
module tb_irq_ctrl_n;

  localparam int          N    = 8;
  localparam int          S    = 2;
  localparam logic [13:0] BASE = 14'h3E80;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] int_src;
  logic         meie;
  logic         rmie;
  logic         g_int;
  logic         g_1shot;
  logic         we;
  logic [13:0]  wadr;
  logic [31:0]  wdata;
  logic [13:0]  radr;
  logic         radr_en;
  logic [31:0]  rdata_in;
  logic [31:0]  rdata;

  int n_cmp = 0;
  int n_mis = 0;

  irq_ctrl_n #(
    .NUM_SRC    (N),
    .SYNC_STAGES(S),
    .BASE_ADR   (BASE)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .int_src          (int_src),
    .csr_meie         (meie),
    .csr_rmie         (rmie),
    .g_interrupt      (g_int),
    .g_interrupt_1shot(g_1shot),
    .dma_io_we        (we),
    .dma_io_wadr      (wadr),
    .dma_io_wdata     (wdata),
    .dma_io_radr      (radr),
    .dma_io_radr_en   (radr_en),
    .dma_io_rdata_in  (rdata_in),
    .dma_io_rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Behavioural model: register contents plus a history of sampled inputs.
  logic [N-1:0] m_en, m_mode, m_pol, m_st, m_prev;
  logic [N-1:0] m_hist[$];
  logic         m_gdly;
  logic         m_rd_hit;
  logic [2:0]   m_rd_ofs;

  function automatic logic m_g();
    return (|(m_st & m_en)) & rmie;
  endfunction

  function automatic logic [31:0] m_claim();
    logic [N-1:0] p;
    p = m_st & m_en;
    for (int i = 0; i < N; i++) begin
      if (p[i]) return {1'b1, 23'd0, 8'(i)};
    end
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_reg(input logic [2:0] ofs);
    logic [31:0] v;
    v = '0;
    case (ofs)
      3'd0: v[N-1:0] = m_en;
      3'd1: v[N-1:0] = m_st;
      3'd2: v[N-1:0] = m_mode;
      3'd3: v[N-1:0] = m_pol;
      3'd4: v = m_claim();
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_en = '0; m_mode = '0; m_pol = '0; m_st = '0; m_prev = '0;
    m_gdly = 1'b0; m_rd_hit = 1'b0; m_rd_ofs = '0;
    m_hist.delete();
    for (int i = 0; i < S; i++) m_hist.push_back('0);
  endtask

  // Advances the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic [N-1:0] sync, adj, rise, lvl, clr, wmask;
    logic         wr_blk;
    logic [2:0]   wofs;
    sync   = m_hist[S-1];
    adj    = sync ^ m_pol;
    wr_blk = we && (wadr[13:3] == BASE[13:3]);
    wofs   = wadr[2:0];
    wmask  = wdata[N-1:0];
    m_gdly = m_g();
    lvl    = adj & m_en & {N{meie}};
    rise   = adj & ~m_prev & m_en & {N{meie}};
    clr    = (wr_blk && wofs == 3'd1) ? wmask : '0;
    m_st   = (m_mode & lvl) | (~m_mode & (rise | (m_st & ~clr)));
    m_prev = (wr_blk && wofs == 3'd3) ? (sync ^ wmask) : adj;
    if (wr_blk) begin
      if (wofs == 3'd0) m_en   = wmask;
      if (wofs == 3'd2) m_mode = wmask;
      if (wofs == 3'd3) m_pol  = wmask;
    end
    m_hist.push_front(int_src);
    void'(m_hist.pop_back());
    m_rd_hit = radr_en && (radr[13:3] == BASE[13:3]);
    m_rd_ofs = radr[2:0];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (rst_n) model_step();
    @(posedge clk);
    @(negedge clk);
    chk("g_interrupt", 32'(g_int), 32'(m_g()));
    chk("g_1shot", 32'(g_1shot), 32'(m_g() & ~m_gdly));
    chk("rdata", rdata, m_rd_hit ? m_reg(m_rd_ofs) : rdata_in);
  endtask

  task automatic bus_write(input int ofs, input logic [31:0] d);
    we = 1'b1; wadr = BASE + 14'(ofs); wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic bus_read(input int ofs, output logic [31:0] v);
    radr_en = 1'b1; radr = BASE + 14'(ofs);
    tick();
    radr_en = 1'b0;
    v = rdata;
  endtask

  initial begin
    logic [31:0] v;
    logic [N-1:0] mask;

    rst_n = 1'b0; int_src = '0; meie = 1'b0; rmie = 1'b0;
    we = 1'b0; wadr = '0; wdata = '0; radr = '0; radr_en = 1'b0;
    rdata_in = 32'hA5A5_0000;
    model_reset();
    #1;
    chk("rst_g", 32'(g_int), 32'd0);
    chk("rst_1shot", 32'(g_1shot), 32'd0);
    chk("rst_rdata", rdata, 32'hA5A5_0000);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset values and read latency
    for (int o = 0; o < 8; o++) begin
      bus_read(o, v);
      chk($sformatf("rst_reg%0d", o), v, 32'd0);
    end
    bus_read(8, v);
    chk("unrelated_passthru", v, 32'hA5A5_0000);
    radr_en = 1'b1; radr = BASE + 14'd4;
    #1 chk("rd_latency_pre", rdata, 32'hA5A5_0000);
    @(negedge clk);
    radr_en = 1'b0;
    bus_write(0, 32'h0000_0005);
    chk("rd_after_strobe", rdata, 32'hA5A5_0000);

    // Rising edge on src2
    meie = 1'b1; rmie = 1'b1;
    int_src[2] = 1'b1;
    tick(); tick();
    chk("edge_lat_g_early", 32'(g_int), 32'd0);
    tick();
    chk("edge_lat_g", 32'(g_int), 32'd1);
    chk("edge_1shot", 32'(g_1shot), 32'd1);
    tick();
    chk("edge_1shot_end", 32'(g_1shot), 32'd0);
    bus_read(1, v); chk("status_src2", v, 32'h04);
    bus_read(4, v); chk("claim_src2", v, 32'h8000_0002);

    // Set wins over simultaneous W1C
    int_src[2] = 1'b0;
    repeat (4) tick();
    int_src[2] = 1'b1;
    tick(); tick();
    bus_write(1, 32'h04);
    bus_read(1, v); chk("set_wins", v, 32'h04);
    bus_write(1, 32'h04);
    bus_read(1, v); chk("w1c_clears", v, 32'h00);
    chk("w1c_g", 32'(g_int), 32'd0);

    // Level mode, active low on src0
    bus_write(2, 32'h01);
    bus_write(3, 32'h01);
    tick();
    bus_read(1, v); chk("level_active_low", v, 32'h01);
    bus_write(1, 32'h01);
    bus_read(1, v); chk("level_w1c_ignored", v, 32'h01);
    int_src[0] = 1'b1;
    tick(); tick();
    chk("level_hold_g", 32'(g_int), 32'd1);
    bus_read(1, v); chk("level_release", v, 32'h00);
    bus_write(2, 32'h00);
    bus_write(3, 32'h00);

    // Priority among src3 and src6, and rmie gating
    bus_write(0, 32'h48);
    int_src[3] = 1'b1; int_src[6] = 1'b1;
    repeat (3) tick();
    bus_read(4, v); chk("claim_3", v, 32'h8000_0003);
    bus_write(1, 32'h08);
    bus_read(4, v); chk("claim_6", v, 32'h8000_0006);
    rmie = 1'b0;
    tick();
    chk("rmie_gate_g", 32'(g_int), 32'd0);
    bus_read(1, v); chk("rmie_status_kept", v, 32'h40);
    rmie = 1'b1;
    #1;
    chk("rmie_g", 32'(g_int), 32'd1);
    chk("rmie_1shot", 32'(g_1shot), 32'd1);
    @(negedge clk);
    bus_write(1, 32'h40);

    // Polarity flip with src1 held high, then meie gating
    int_src[1] = 1'b1;
    repeat (4) tick();
    bus_write(0, 32'h02);
    bus_write(3, 32'h02);
    repeat (3) tick();
    bus_write(3, 32'h00);
    repeat (4) tick();
    bus_read(1, v); chk("pol_flip_no_edge", v, 32'h00);
    int_src[1] = 1'b0;
    repeat (4) tick();
    meie = 1'b0;
    int_src[1] = 1'b1;
    repeat (4) tick();
    meie = 1'b1;
    tick();
    bus_read(1, v); chk("meie_gate", v, 32'h00);

    // Reset while pending
    bus_write(0, 32'h80);
    int_src[7] = 1'b1;
    repeat (3) tick();
    chk("pre_reset_g", 32'(g_int), 32'd1);
    bus_read(1, v); chk("pre_reset_rd", v, 32'h80);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_g", 32'(g_int), 32'd0);
    chk("mid_rst_1shot", 32'(g_1shot), 32'd0);
    chk("mid_rst_rdata", rdata, 32'hA5A5_0000);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    bus_read(0, v); chk("post_rst_enable", v, 32'h00);

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      mask     = N'($urandom & $urandom & $urandom);
      int_src  = int_src ^ mask;
      meie     = ($urandom_range(0, 7) != 0);
      rmie     = ($urandom_range(0, 7) != 0);
      we       = ($urandom_range(0, 3) == 0);
      wadr     = BASE + 14'($urandom_range(0, 9));
      wdata    = $urandom;
      radr_en  = ($urandom_range(0, 1) == 0);
      radr     = ($urandom_range(0, 7) == 0) ? 14'($urandom) : BASE + 14'($urandom_range(0, 9));
      rdata_in = $urandom;
      tick();
    end
    we = 1'b0; radr_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
